// File: rtl/round_robin_arbiter_8.sv
// round_robin_arbiter_8: 8-way round-robin arbiter with registered one-hot grant.
// An owner keeps the grant while its request stays high. When the request drops,
// the remaining requesters are arbitrated on that same edge, starting just after
// the previous owner.
// Optional macro ARB_HOLD_LIMIT_EN adds a 4-bit hold counter. It forces rotation
// after HOLD_MAX cycles, but only when another requester is waiting.
module round_robin_arbiter_8 #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_e;

  // HOLD_MAX must fit the 4-bit hold counter and leave room for a real hold.
  if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_bad_hold_max
    $error("HOLD_MAX out of range 2..15");
  end

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] own_q, own_d;
`ifdef ARB_HOLD_LIMIT_EN
  logic [3:0] cnt_q, cnt_d;
`endif

  logic [7:0] others;
  logic       rel;
  logic       force_rr;
  logic [3:0] pick_idle;
  logic [3:0] pick_re;

  // Return {found, index} for the first set bit of cand.
  // The search starts at p and wraps modulo 8.
  function automatic logic [3:0] arb_pick(input logic [7:0] cand, input logic [2:0] p);
    logic       f;
    logic [2:0] w;
    logic [2:0] i;
    f = 1'b0;
    w = 3'd0;
    for (int k = 0; k < 8; k++) begin
      i = p + 3'(k);
      if (!f && cand[i]) begin
        f = 1'b1;
        w = i;
      end
    end
    return {f, w};
  endfunction

  // State register: reset clears every piece of state, overriding req.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      own_q   <= 3'd0;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next state: hold the grant, re-arbitrate on release (or forced rotation),
  // or pick a fresh winner from idle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
`ifdef ARB_HOLD_LIMIT_EN
    cnt_d     = cnt_q;
`endif
    // The current owner is always excluded from re-arbitration.
    others    = req & ~(8'b1 << own_q);
    rel       = !req[own_q];
`ifdef ARB_HOLD_LIMIT_EN
    force_rr  = (cnt_q == 4'(HOLD_MAX - 1)) && (|others);
`else
    force_rr  = 1'b0;
`endif
    pick_idle = arb_pick(req, ptr_q);
    pick_re   = arb_pick(others, own_q + 3'd1);
    case (state_q)
      S_IDLE: begin
        if (pick_idle[3]) begin
          state_d = S_GRANT;
          own_d   = pick_idle[2:0];
`ifdef ARB_HOLD_LIMIT_EN
          cnt_d   = 4'd0;
`endif
        end
      end
      S_GRANT: begin
        if (rel || force_rr) begin
          ptr_d = own_q + 3'd1;
          if (pick_re[3]) begin
            own_d = pick_re[2:0];
          end else begin
            state_d = S_IDLE;
            own_d   = 3'd0;
          end
`ifdef ARB_HOLD_LIMIT_EN
          cnt_d = 4'd0;
`endif
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
          // At the limit with nobody else waiting, the owner keeps the grant
          // and the count starts over.
          cnt_d = (cnt_q == 4'(HOLD_MAX - 1)) ? 4'd0 : cnt_q + 4'd1;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
        own_d   = 3'd0;
      end
    endcase
  end

  // Outputs are decoded purely from registered state, so they change only at clock edges.
  always_comb begin
    gnt_valid = (state_q == S_GRANT);
    gnt       = gnt_valid ? (8'b1 << own_q) : 8'b0;
    gnt_idx   = gnt_valid ? own_q : 3'd0;
  end

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Testbench for round_robin_arbiter_8.
// Drives directed scenarios and randomized requests, and compares every cycle
// against a behavioural model of owner, pointer and hold count.
module tb_round_robin_arbiter_8;

  localparam int HOLD_MAX = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int nvec = 0;
  int nerr = 0;

  // Reference model state: m_own is -1 when nothing is granted.
  int m_own = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  round_robin_arbiter_8 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  // Return the first requester at or after start, counting modulo 8.
  function automatic int pick(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic [7:0] r, input bit rs);
    logic [7:0] oth;
    bit         frc;
    if (rs) begin
      m_own = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_own < 0) begin
      m_own = pick(r, m_ptr);
      m_cnt = 0;
    end else begin
      oth = r;
      oth[m_own] = 1'b0;
      frc = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      frc = (m_cnt == HOLD_MAX - 1) && (oth != 8'h00);
`endif
      if (!r[m_own] || frc) begin
        m_ptr = (m_own + 1) % 8;
        m_own = pick(oth, m_ptr);
        m_cnt = 0;
      end else begin
`ifdef ARB_HOLD_LIMIT_EN
        m_cnt = (m_cnt == HOLD_MAX - 1) ? 0 : m_cnt + 1;
`endif
      end
    end
  endfunction

  // Model outputs packed as {gnt, gnt_idx, gnt_valid}.
  function automatic logic [11:0] exp_out();
    if (m_own < 0) return 12'h000;
    return {8'(1 << m_own), 3'(m_own), 1'b1};
  endfunction

  // Apply one cycle of stimulus and step the model at the same edge.
  // Outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic [7:0] r, input bit rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
  endtask

  task automatic test_reset();
    cyc(8'hFF, 1'b1);
    cyc(8'hFF, 1'b1);
    nvec++;
    if ({gnt, gnt_idx, gnt_valid} !== 12'h000) begin
      nerr++;
      $display("FAIL reset: got gnt=%b idx=%0d v=%b, want all zero", gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 5; i++) begin
      cyc(8'h00, 1'b0);
      nvec++;
      if ({gnt, gnt_idx, gnt_valid} !== 12'h000) begin
        nerr++;
        $display("FAIL idle%0d: got gnt=%b idx=%0d v=%b, want all zero", i, gnt, gnt_idx, gnt_valid);
      end
    end
  endtask

  task automatic test_basic();
    cyc(8'h00, 1'b1);
    cyc(8'b11001100, 1'b0);
    nvec++;
    if (gnt !== 8'b00000100 || gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
      nerr++;
      $display("FAIL basic_first: got gnt=%b idx=%0d v=%b, want 00000100 idx 2", gnt, gnt_idx, gnt_valid);
    end
    cyc(8'b11001100, 1'b0);
    cyc(8'b11001000, 1'b0);
    nvec++;
    if (gnt !== 8'b00001000 || gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin
      nerr++;
      $display("FAIL basic_release: got gnt=%b idx=%0d v=%b, want 00001000 idx 3", gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_wrap();
    cyc(8'h00, 1'b1);
    cyc(8'h80, 1'b0);
    cyc(8'b10010010, 1'b0);
    nvec++;
    if (gnt_idx !== 3'd7 || gnt_valid !== 1'b1) begin
      nerr++;
      $display("FAIL wrap_hold7: got idx=%0d v=%b, want idx 7", gnt_idx, gnt_valid);
    end
    cyc(8'b00010010, 1'b0);
    nvec++;
    if (gnt !== 8'b00000010 || gnt_idx !== 3'd1) begin
      nerr++;
      $display("FAIL wrap_to1: got gnt=%b idx=%0d, want 00000010 idx 1", gnt, gnt_idx);
    end
    cyc(8'b00010010, 1'b0);
    nvec++;
    if (gnt_idx !== 3'd1) begin
      nerr++;
      $display("FAIL wrap_hold1: got idx=%0d, want 1", gnt_idx);
    end
    cyc(8'b00010000, 1'b0);
    nvec++;
    if (gnt !== 8'b00010000 || gnt_idx !== 3'd4) begin
      nerr++;
      $display("FAIL wrap_to4: got gnt=%b idx=%0d, want 00010000 idx 4", gnt, gnt_idx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    cyc(8'h00, 1'b1);
    cyc(8'hFF, 1'b0);
    for (int s = 0; s <= 8; s++) begin
      for (int c = 0; c < 3; c++) begin
        nvec++;
        if (gnt_idx !== 3'(s % 8) || gnt_valid !== 1'b1 || gnt !== 8'(1 << (s % 8))) begin
          nerr++;
          $display("FAIL b2b s%0d c%0d: got gnt=%b idx=%0d v=%b, want idx %0d",
                   s, c, gnt, gnt_idx, gnt_valid, s % 8);
        end
        r = 8'hFF;
        if (c == 2) r[s % 8] = 1'b0;
        cyc(r, 1'b0);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(8'h00, 1'b1);
    cyc(8'h20, 1'b0);
    cyc(8'h20, 1'b0);
    nvec++;
    if (gnt_idx !== 3'd5 || gnt_valid !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_own5: got idx=%0d v=%b, want idx 5", gnt_idx, gnt_valid);
    end
    cyc(8'h20, 1'b1);
    nvec++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      nerr++;
      $display("FAIL rstmid_drop: got gnt=%b idx=%0d v=%b, want zero", gnt, gnt_idx, gnt_valid);
    end
    cyc(8'b00100001, 1'b0);
    nvec++;
    if (gnt_idx !== 3'd0 || gnt !== 8'h01 || gnt_valid !== 1'b1) begin
      nerr++;
      $display("FAIL rstmid_ptr0: got gnt=%b idx=%0d v=%b, want idx 0", gnt, gnt_idx, gnt_valid);
    end
  endtask

`ifdef ARB_HOLD_LIMIT_EN
  task automatic test_hold_limit();
    cyc(8'h00, 1'b1);
    cyc(8'h03, 1'b0);
    for (int n = 0; n < 40; n++) begin
      nvec++;
      if (gnt_idx !== 3'((n / HOLD_MAX) % 2) || gnt_valid !== 1'b1) begin
        nerr++;
        $display("FAIL hold_alt n%0d: got idx=%0d v=%b, want %0d", n, gnt_idx, gnt_valid, (n / HOLD_MAX) % 2);
      end
      cyc(8'h03, 1'b0);
    end
    cyc(8'h00, 1'b1);
    for (int n = 0; n < 30; n++) begin
      cyc(8'h01, 1'b0);
      nvec++;
      if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
        nerr++;
        $display("FAIL hold_solo n%0d: got gnt=%b idx=%0d v=%b, want owner 0", n, gnt, gnt_idx, gnt_valid);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  cur;
    logic [11:0] e;
    bit          rs;
    cur = 8'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(2, 0) == 0) cur = cur ^ 8'(1 << $urandom_range(7, 0));
      if (m_own >= 0 && $urandom_range(3, 0) == 0) cur[m_own] = 1'b0;
      if ($urandom_range(15, 0) == 0) cur = 8'($urandom);
      rs = ($urandom_range(63, 0) == 0);
      cyc(cur, rs);
      e = exp_out();
      nvec++;
      if ({gnt, gnt_idx, gnt_valid} !== e) begin
        nerr++;
        $display("FAIL random%0d req=%b: got gnt=%b idx=%0d v=%b, want gnt=%b idx=%0d v=%b",
                 i, cur, gnt, gnt_idx, gnt_valid, e[11:4], e[3:1], e[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef ARB_HOLD_LIMIT_EN
    test_hold_limit();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
